// File: rtl/fpu_operand_loader.sv
// Front end of the 16-bit FPU: collects operand A, operand B and opcode over a
// valid/ready stream, unpacks the halves, and sequences the control-stage start burst.
module fpu_operand_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [17:0] A,
    output logic [17:0] B,
    output logic [1:0]  O,
    output logic        start,
    input  logic        done,
    output logic        busy,
    output logic        exc,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_LOAD_OP,
        S_ISSUE,
        S_WAIT_DONE
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0] EXP_SPECIAL = 5'h1F;

    state_e      state_q, state_d;
    logic [17:0] a_q, a_d;
    logic [17:0] b_q, b_d;
    logic [1:0]  o_q, o_d;
    logic [1:0]  issue_cnt_q, issue_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        exc_q, exc_d;
    logic        timeout_q, timeout_d;

    // Bit 11 stays zero as carry headroom; hidden bit is clear for zero/subnormals.
    function automatic logic [17:0] unpack_half(input logic [15:0] w);
        return {w[15], w[14:10], 1'b0, (w[14:10] != 5'd0), w[9:0]};
    endfunction

    // Handshake, start and busy are Moore decodes so no input reaches an output.
    assign din_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) ||
                       (state_q == S_LOAD_OP);
    assign start     = (state_q == S_ISSUE);
    assign busy      = (state_q != S_IDLE);
    assign A         = a_q;
    assign B         = b_q;
    assign O         = o_q;
    assign exc       = exc_q;
    assign timeout   = timeout_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        o_d         = o_q;
        issue_cnt_d = issue_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        exc_d       = 1'b0;
        timeout_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                issue_cnt_d = 2'd0;
                wait_cnt_d  = 8'd0;
                if (go) begin
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                if (din_valid) begin
                    a_d     = unpack_half(din);
                    state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (din_valid) begin
                    b_d     = unpack_half(din);
                    state_d = S_LOAD_OP;
                end
            end
            S_LOAD_OP: begin
                if (din_valid) begin
                    o_d = din[1:0];
                    if ((a_q[16:12] == EXP_SPECIAL) || (b_q[16:12] == EXP_SPECIAL)) begin
                        exc_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        issue_cnt_d = 2'd0;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                issue_cnt_d = issue_cnt_q + 2'd1;
                if (issue_cnt_q == 2'd3) begin
                    wait_cnt_d = 8'd0;
                    state_d    = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // done has priority over a timeout falling on the same cycle.
                if (done) begin
                    wait_cnt_d = 8'd0;
                    state_d    = S_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = 8'd0;
                    timeout_d  = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= 18'd0;
            b_q         <= 18'd0;
            o_q         <= 2'd0;
            issue_cnt_q <= 2'd0;
            wait_cnt_q  <= 8'd0;
            exc_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            o_q         <= o_d;
            issue_cnt_q <= issue_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            exc_q       <= exc_d;
            timeout_q   <= timeout_d;
        end
    end

endmodule

// File: doc/fpu_operand_loader.md
# fpu_operand_loader

Upstream front end of the 16-bit FPU. It accepts three words (operand A, operand B, opcode) over a valid/ready stream, unpacks each IEEE-754 half operand into the 18-bit internal format used by the FPU control stage, and screens out special operands. It then drives the four `start` pulses that walk the FPU control stage from its idle state to operation select, and waits for that stage's `ready`/`error` completion, with a timeout.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of WAIT_DONE cycles before the load is abandoned (1..255).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `go`  in  1  one-cycle request to begin a new load; honoured only in IDLE.
- `din`  in  16  data word: raw half-precision operand, or opcode in `din[1:0]`.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  loader accepts `din` this cycle.
- `A`  out  18  unpacked operand A, laid out as {sign, exp[4:0], 1'b0, hidden, frac[9:0]}.
- `B`  out  18  unpacked operand B, same layout as `A`.
- `O`  out  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
- `start`  out  1  advance strobe to the FPU control stage.
- `done`  in  1  completion from the FPU control stage (`ready | error`).
- `busy`  out  1  high in every state except IDLE.
- `exc`  out  1  one-cycle pulse: load rejected because of a special operand.
- `timeout`  out  1  one-cycle pulse: `done` did not arrive in time.

## Operation
- Unpack rule, for operand word w:
  - `{w[15], w[14:10], 1'b0, (w[14:10]!=0), w[9:0]}`.
  - Subnormals and zero therefore have hidden = 0.
  - Bit 11 is always 0; it is the carry headroom for the downstream stage.
- States: IDLE, LOAD_A, LOAD_B, LOAD_OP, ISSUE, WAIT_DONE.
  - IDLE: on `go` -> LOAD_A.
  - LOAD_A: on accept, register `A` -> LOAD_B.
  - LOAD_B: on accept, register `B` -> LOAD_OP.
  - LOAD_OP: on accept, register `O` = `din[1:0]`, ignoring `din[15:2]`.
    - If `A[16:12]==31` or `B[16:12]==31` (Inf/NaN): pulse `exc`, go to IDLE, no `start`.
    - Otherwise -> ISSUE.
  - ISSUE: `start` is high. A 2-bit counter counts exactly 4 cycles, then -> WAIT_DONE.
  - WAIT_DONE: a cycle counter starts at 0 on entry.
    - On `done` -> IDLE.
    - Else, when the count reaches TIMEOUT_CYCLES-1 -> pulse `timeout` and go to IDLE.
- Accept condition: `din_valid & din_ready`.
  - `din_ready` = state is LOAD_A, LOAD_B or LOAD_OP (Moore).
  - `din_valid` without `din_ready` is ignored; no data is dropped or buffered.
- `A`, `B`, `O` change only on their own accept. They hold stable through ISSUE, WAIT_DONE and IDLE until the next load overwrites them.
- Boundary behaviour:
  - `go` outside IDLE is ignored.
  - `done` during ISSUE or LOAD_* is ignored.
  - `done` in the same cycle the timeout would fire: `done` wins, no `timeout`.
  - `exc` and `timeout` are never both high in one cycle.
  - An opcode word is never an exception; every 2-bit value is legal.

## Timing
- Reset values: state IDLE; `A`=0, `B`=0, `O`=0; `start`=0, `din_ready`=0, `busy`=0, `exc`=0, `timeout`=0; all counters 0.
- `rst` mid-operation: the state machine and outputs return to reset values at the next edge. This includes `start` dropping, even in the middle of a burst.
- All outputs are registered or Moore-decoded from state. No combinational path from any input to any output.
- `go` sampled high at edge k: `din_ready` is high from cycle k+1.
- OP accepted at edge k (no exception): `start` is high for cycles k+1..k+4, and `busy` stays high throughout.
- Exception path: OP accepted at edge k -> `exc` high only in cycle k+1, with state IDLE and `busy`=0.
- Timeout: with no `done`, `timeout` pulses in the cycle after the TIMEOUT_CYCLES-th WAIT_DONE cycle. `busy` falls in that same cycle.
- Minimum load: 1 (go) + 3 (words, back-to-back valid) + 4 (ISSUE) + ≥1 (WAIT_DONE) cycles.

## Test plan
- Reset, then `go`, then words 0x3C00, 0x4000, 0x0000 back-to-back -> `A`=18'h0F400, `B`=18'h10400, `O`=00; `start` high for 4 consecutive cycles; `done` two cycles later -> `busy` low, no `exc`/`timeout`.
- Operands 0xBC00 and 0x0001, opcode 0x0003 -> `A`=18'h2F400, `B`=18'h00001 (hidden bit 0), `O`=11. Insert `din_valid` gaps of 3 cycles -> each word is accepted exactly once.
- Operand B = 0x7C00 (Inf) -> `exc` pulses 1 cycle after the opcode is accepted; `start` never asserted; state IDLE.
- TIMEOUT_CYCLES=8, `done` held low -> `timeout` pulses exactly once after 8 WAIT_DONE cycles. Repeat with `done` on cycle 8 -> `done` wins, no `timeout`.
- `go` pulsed during LOAD_B and during WAIT_DONE -> no effect.
- `rst` asserted on the 2nd `start` cycle -> next cycle all outputs are at reset values.
